// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: data format and the drain/feeder job FSM states.
package sa_pkg;
  localparam int DW   = 16;
  localparam int FRAC = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sa_col_fifo.sv
// Per-column synchronous FIFO; a pop frees the slot so a push into a full FIFO succeeds that cycle.
module sa_col_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sa_drain.sv
// Bottom-edge collector: deskews per-column PE outputs through column FIFOs into aligned rows.
module sa_drain
  import sa_pkg::*;
#(
  parameter int N     = 8,
  parameter int DW    = sa_pkg::DW,
  parameter int DEPTH = 8
) (
  input  logic            I_CLK,
  input  logic            I_RST,
  input  logic            I_START,
  input  logic [7:0]      I_ROWS,
  input  logic [N-1:0]    I_COL_VLD,
  input  logic [N*DW-1:0] I_COL_D,
  output logic            O_VLD,
  input  logic            I_RDY,
  output logic [N*DW-1:0] O_ROW,
  output logic            O_LAST,
  output logic            O_DONE,
  output logic            O_AFULL,
  output logic            O_OVF
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t state, state_nx;
  logic [7:0] rows_m1, row_cnt;
  logic [N-1:0][DW-1:0] col_d, col_head;
  logic [N-1:0][CW-1:0] col_cnt;
  logic [N-1:0] col_push, col_full, col_empty, col_ovf, col_af;
  logic run, hs, fin, load, flush;

  assign col_d  = I_COL_D;
  assign run    = (state == RUN);
  assign hs     = O_VLD & I_RDY;
  assign O_LAST = O_VLD & (row_cnt == rows_m1);
  assign fin    = hs & O_LAST;
  // No load on the final handshake: surplus rows stay buffered until the flush.
  assign load   = run & ~|col_empty & (~O_VLD | I_RDY) & ~fin;
  assign flush  = (state == DONE);
  assign O_DONE = (state == DONE);

  for (genvar j = 0; j < N; j++) begin : g_col
    assign col_push[j] = run & I_COL_VLD[j];
    assign col_ovf[j]  = col_push[j] & col_full[j] & ~load;
    assign col_af[j]   = (col_cnt[j] >= CW'(DEPTH - 1));

    sa_col_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (I_CLK),
      .rst   (I_RST),
      .flush (flush),
      .push  (col_push[j]),
      .pop   (load),
      .din   (col_d[j]),
      .head  (col_head[j]),
      .count (col_cnt[j]),
      .full  (col_full[j]),
      .empty (col_empty[j])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (I_START) state_nx = RUN;
      RUN:     if (fin) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state   <= IDLE;
      rows_m1 <= '0;
      row_cnt <= '0;
      O_VLD   <= 1'b0;
      O_ROW   <= '0;
      O_AFULL <= 1'b0;
      O_OVF   <= 1'b0;
    end else begin
      state <= state_nx;
      // I_ROWS of 0 wraps to 255 here, giving a 256-row job.
      if (state == IDLE && I_START) begin
        rows_m1 <= I_ROWS - 8'd1;
        row_cnt <= '0;
      end else if (hs) begin
        row_cnt <= row_cnt + 8'd1;
      end
      if (load) begin
        O_VLD <= 1'b1;
        O_ROW <= col_head;
      end else if (hs) begin
        O_VLD <= 1'b0;
      end
      O_AFULL <= |col_af;
      if (|col_ovf) O_OVF <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain with N=4, DEPTH=8.
module tb_sa_drain;
  localparam int N = 4, DW = 16, DEPTH = 8;

  logic            I_CLK = 1'b0;
  logic            I_RST, I_START, I_RDY;
  logic [7:0]      I_ROWS;
  logic [N-1:0]    I_COL_VLD;
  logic [N*DW-1:0] I_COL_D;
  logic            O_VLD, O_LAST, O_DONE, O_AFULL, O_OVF;
  logic [N*DW-1:0] O_ROW;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, t0 = 0;
  bit afull_seen = 0, stall_prev = 0;
  logic [N*DW-1:0] row_prev;
  logic [N*DW-1:0] got_row[$];
  logic            got_last[$];
  int              got_cyc[$];

  sa_drain #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_ROWS(I_ROWS),
    .I_COL_VLD(I_COL_VLD), .I_COL_D(I_COL_D), .O_VLD(O_VLD), .I_RDY(I_RDY),
    .O_ROW(O_ROW), .O_LAST(O_LAST), .O_DONE(O_DONE), .O_AFULL(O_AFULL), .O_OVF(O_OVF)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Sample just after the driving edge: these are the values the next rising edge sees.
  always begin
    @(negedge I_CLK); #1;
    cyc++;
    if (O_VLD && I_RDY) begin
      got_row.push_back(O_ROW); got_last.push_back(O_LAST); got_cyc.push_back(cyc);
    end
    if (O_DONE) begin done_cnt++; done_cyc = cyc; end
    if (O_AFULL) afull_seen = 1;
    if (stall_prev) begin
      chk("hold_vld", 64'(O_VLD), 64'd1);
      chk("hold_row", O_ROW, row_prev);
    end
    stall_prev = O_VLD && !I_RDY;
    row_prev   = O_ROW;
  end

  function automatic logic [N*DW-1:0] row_of(input int r, input logic [15:0] base);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = base + 16'(16*r + j);
    return v;
  endfunction

  task automatic clr();
    got_row.delete(); got_last.delete(); got_cyc.delete();
    done_cnt = 0; afull_seen = 0;
  endtask

  task automatic step(input logic [N-1:0] vld, input logic [N*DW-1:0] d, input logic rdy);
    @(negedge I_CLK);
    I_START = 1'b0; I_COL_VLD = vld; I_COL_D = d; I_RDY = rdy;
  endtask

  task automatic start_job(input logic [7:0] rows);
    @(negedge I_CLK);
    I_START = 1'b1; I_ROWS = rows; I_COL_VLD = '0; I_RDY = 1'b1;
  endtask

  // Skewed stimulus: column j of row r is driven in cycle r+j; I_RDY low for cycles [st_lo, st_hi).
  task automatic run_skew(input int nr, input int c_end, input int st_lo, input int st_hi);
    logic [N-1:0] v; logic [N*DW-1:0] d;
    for (int c = 0; c < c_end; c++) begin
      v = '0; d = '0;
      for (int j = 0; j < N; j++) begin
        if (c - j >= 0 && c - j < nr) begin
          v[j] = 1'b1; d[j*DW +: DW] = 16'h2000 + 16'(16*(c-j) + j);
        end
      end
      step(v, d, !(c >= st_lo && c < st_hi));
      if (c == 0) t0 = cyc;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin step('0, '0, 1'b1); k++; end
    chk("done_seen", 64'(done_cnt), 64'd1);
    step('0, '0, 1'b1); step('0, '0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] d;
    int nl;
    I_RST = 1'b1; I_START = 1'b0; I_ROWS = '0; I_COL_VLD = '0; I_COL_D = '0; I_RDY = 1'b1;
    repeat (3) @(negedge I_CLK);
    #1;
    chk("rst_vld", 64'(O_VLD), 0);  chk("rst_row", O_ROW, 0);
    chk("rst_last", 64'(O_LAST), 0); chk("rst_done", 64'(O_DONE), 0);
    chk("rst_afull", 64'(O_AFULL), 0); chk("rst_ovf", 64'(O_OVF), 0);
    @(negedge I_CLK); I_RST = 1'b0;

    // Basic 3-row job, full throughput.
    clr(); start_job(8'd3); run_skew(3, 8, 99, 99); drain(20);
    chk("t1_nrows", 64'(got_row.size()), 3);
    chk("t1_row0", got_row[0], 64'h2003_2002_2001_2000);
    chk("t1_row1", got_row[1], 64'h2013_2012_2011_2010);
    chk("t1_row2", got_row[2], 64'h2023_2022_2021_2020);
    chk("t1_lat", 64'(got_cyc[0] - t0), N + 2);
    chk("t1_b2b1", 64'(got_cyc[1] - got_cyc[0]), 1);
    chk("t1_b2b2", 64'(got_cyc[2] - got_cyc[1]), 1);
    chk("t1_last", {61'd0, got_last[2], got_last[1], got_last[0]}, 64'b100);
    chk("t1_done_t", 64'(done_cyc - got_cyc[2]), 1);

    // 9 rows with a 10-cycle stall from first O_VLD: fills FIFOs to DEPTH without loss.
    clr(); start_job(8'd9); run_skew(9, 15, N + 1, N + 11); drain(40);
    chk("t2_nrows", 64'(got_row.size()), 9);
    for (int r = 0; r < got_row.size(); r++) chk($sformatf("t2_row%0d", r), got_row[r], row_of(r, 16'h2000));
    chk("t2_afull", 64'(afull_seen), 1);
    chk("t2_ovf", 64'(O_OVF), 0);

    // Overflow: 9 words into column 0 while other columns are empty.
    clr(); start_job(8'd8);
    for (int i = 0; i < 9; i++) step(4'b0001, 64'(16'h1000 + 16'(i)), 1'b0);
    step('0, '0, 1'b1); #1;
    chk("t3_ovf_set", 64'(O_OVF), 1);
    for (int r = 0; r < 8; r++) begin
      d = row_of(r, 16'h3000); d[15:0] = '0;
      step(4'b1110, d, 1'b1);
    end
    drain(30);
    chk("t3_nrows", 64'(got_row.size()), 8);
    for (int i = 0; i < got_row.size(); i++) chk($sformatf("t3_c0_%0d", i), 64'(got_row[i][15:0]), 64'(16'h1000 + 16'(i)));
    chk("t3_c1_7", 64'(got_row[7][31:16]), 64'h3071);
    chk("t3_ovf_sticky", 64'(O_OVF), 1);
    @(negedge I_CLK); I_RST = 1'b1;
    @(negedge I_CLK); I_RST = 1'b0; #1;
    chk("t3_ovf_rst", 64'(O_OVF), 0);

    // Push and pop together on a full column 0.
    clr(); start_job(8'd9);
    for (int i = 0; i < 8; i++) step(4'b0001, 64'(16'h4000 + 16'(i)), 1'b1);
    d = row_of(0, 16'h5000); d[15:0] = '0; step(4'b1110, d, 1'b1);
    d = row_of(1, 16'h5000); d[15:0] = 16'h4008; step(4'b1111, d, 1'b1);
    d = row_of(2, 16'h5000); d[15:0] = '0; step(4'b1110, d, 1'b1); #1;
    chk("t4_cnt_full", 64'(dut.col_cnt[0]), 8);
    chk("t4_ovf", 64'(O_OVF), 0);
    for (int r = 3; r < 9; r++) begin
      d = row_of(r, 16'h5000); d[15:0] = '0;
      step(4'b1110, d, 1'b1);
    end
    drain(30);
    chk("t4_nrows", 64'(got_row.size()), 9);
    for (int i = 0; i < got_row.size(); i++) chk($sformatf("t4_c0_%0d", i), 64'(got_row[i][15:0]), 64'(16'h4000 + 16'(i)));
    chk("t4_c3_8", 64'(got_row[8][63:48]), 64'h5083);
    chk("t4_ovf_end", 64'(O_OVF), 0);

    // Column valids in IDLE are ignored.
    clr();
    repeat (3) step(4'b1111, row_of(0, 16'h6000), 1'b1);
    step('0, '0, 1'b1); step('0, '0, 1'b1); #1;
    chk("t5_idle_rows", 64'(got_row.size()), 0);
    chk("t5_idle_cnt0", 64'(dut.col_cnt[0]), 0);
    chk("t5_idle_cnt3", 64'(dut.col_cnt[3]), 0);

    // Reset mid-job, then a clean rerun.
    clr(); start_job(8'd3); run_skew(3, 6, 99, 99);
    @(negedge I_CLK); I_RST = 1'b1; I_COL_VLD = '0;
    @(negedge I_CLK); I_RST = 1'b0; #1;
    chk("t6_vld", 64'(O_VLD), 0);   chk("t6_row", O_ROW, 0);
    chk("t6_last", 64'(O_LAST), 0);  chk("t6_afull", 64'(O_AFULL), 0);
    chk("t6_ovf", 64'(O_OVF), 0);
    repeat (6) step('0, '0, 1'b1);
    chk("t6_no_done", 64'(done_cnt), 0);
    clr(); start_job(8'd3); run_skew(3, 8, 99, 99); drain(20);
    chk("t6_nrows", 64'(got_row.size()), 3);
    chk("t6_row0", got_row[0], 64'h2003_2002_2001_2000);
    chk("t6_row2", got_row[2], 64'h2023_2022_2021_2020);

    // I_ROWS=0 runs 256 rows.
    clr(); start_job(8'd0);
    for (int r = 0; r < 256; r++) step(4'b1111, row_of(r, 16'h0000), 1'b1);
    drain(30);
    chk("t7_nrows", 64'(got_row.size()), 256);
    chk("t7_row100", got_row[100], 64'h0643_0642_0641_0640);
    chk("t7_row255", got_row[255], 64'h0FF3_0FF2_0FF1_0FF0);
    nl = 0;
    foreach (got_last[i]) if (got_last[i]) nl++;
    chk("t7_nlast", 64'(nl), 1);
    chk("t7_last255", 64'(got_last[255]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
